btn_debounce: RTL and testbench

// Input-side companion to the board's LED counter demo: takes N raw,

---
 rtl/btn_debounce.sv | 114 +++++++++++
 tb/tb_btn_debounce.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// btn_debounce: N-channel pushbutton front end with synchroniser, stability-counter debounce and press/release pulses.
// Define BTN_HOLD_EN to add per-channel long-press detection on btn_hold; otherwise btn_hold is tied to 0.
module btn_debounce #(
  parameter int N            = 5,
  parameter int LOG2DEBOUNCE = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int LOG2HOLD     = 24
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] btn_raw,
  output logic [N-1:0] btn_state,
  output logic [N-1:0] btn_press,
  output logic [N-1:0] btn_release,
  output logic [N-1:0] btn_hold
);

  localparam logic [LOG2DEBOUNCE-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0][N-1:0]  sync_q, sync_d;
  logic [N-1:0]                   sync;
  logic [N-1:0][LOG2DEBOUNCE-1:0] cnt_q, cnt_d;
  logic [N-1:0]                   state_q, state_d;
  logic [N-1:0]                   press_q, press_d;
  logic [N-1:0]                   release_q, release_d;

  always_comb begin
    sync_d[0] = btn_raw;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // A channel flips only after sync has disagreed with the accepted level for a full counter sweep.
  always_comb begin
    // NOTE: every always_comb output gets its default first, so no branch can leave it unassigned and infer a latch.
    cnt_d     = cnt_q;
    state_d   = state_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N; i++) begin
      if (sync[i] == state_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] != CNT_MAX) begin
        cnt_d[i] = cnt_q[i] + LOG2DEBOUNCE'(1);
      end else begin
        cnt_d[i]     = '0;
        state_d[i]   = sync[i];
        press_d[i]   = sync[i];
        release_d[i] = ~sync[i];
      end
    end
  end

  // NOTE: the counters are plain flops, not a memory, and are reset so a partial count never survives rstn.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      state_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      // NOTE: state uses non-blocking assignment so every flop samples pre-edge values.
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_state   = state_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

`ifdef BTN_HOLD_EN
  localparam logic [LOG2HOLD-1:0] HOLD_MAX = '1;

  logic [N-1:0][LOG2HOLD-1:0] hold_cnt_q, hold_cnt_d;
  logic [N-1:0]               hold_q, hold_d;

  // Saturation makes the pulse fire once per press; only a release clears the counter.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    hold_d     = '0;
    for (int i = 0; i < N; i++) begin
      if (!state_q[i]) begin
        hold_cnt_d[i] = '0;
      end else if (hold_cnt_q[i] != HOLD_MAX) begin
        hold_cnt_d[i] = hold_cnt_q[i] + LOG2HOLD'(1);
        hold_d[i]     = (hold_cnt_q[i] == HOLD_MAX - LOG2HOLD'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_cnt_q <= '0;
      hold_q     <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      hold_q     <= hold_d;
    end
  end

  assign btn_hold = hold_q;
`else
  assign btn_hold = '0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: table vectors, directed corner sequences and random stimulus against a stability-window model.
// Hold expectations follow BTN_HOLD_EN, the same macro the design uses.
module tb_btn_debounce;

  localparam int N            = 2;
  localparam int LOG2DEBOUNCE = 4;
  localparam int SYNC_STAGES  = 2;
  localparam int LOG2HOLD     = 6;
  localparam int DB           = 1 << LOG2DEBOUNCE;
  localparam int HOLD_MAX     = (1 << LOG2HOLD) - 1;
  localparam int LAT          = SYNC_STAGES + DB;

  logic         clk = 1'b0;
  logic         rstn;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_state, btn_press, btn_release, btn_hold;

  btn_debounce #(
    .N(N), .LOG2DEBOUNCE(LOG2DEBOUNCE), .SYNC_STAGES(SYNC_STAGES), .LOG2HOLD(LOG2HOLD)
  ) dut (
    .clk(clk), .rstn(rstn), .btn_raw(btn_raw), .btn_state(btn_state),
    .btn_press(btn_press), .btn_release(btn_release), .btn_hold(btn_hold)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a level is accepted once the synchronised input has held one value,
  // different from the current level, for DB consecutive samples since reset.
  logic [N-1:0] raw_log [64];
  int           cyc;
  int           m_rise [N];
  logic [N-1:0] m_state, m_press, m_release, m_hold, m_now, m_accept;

  function automatic logic [N-1:0] sync_at(input int n);
    if (n < SYNC_STAGES) return '0;
    return raw_log[6'(n - SYNC_STAGES)];
  endfunction

  always_comb begin
    m_now    = sync_at(cyc);
    m_accept = m_now ^ m_state;
    for (int k = 1; k < DB; k++) begin
      m_accept = m_accept & ~(sync_at(cyc - k) ^ m_now);
    end
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cyc       <= 0;
      m_state   <= '0;
      m_press   <= '0;
      m_release <= '0;
      m_hold    <= '0;
      for (int i = 0; i < N; i++) m_rise[i] <= 0;
    end else begin
      cyc                <= cyc + 1;
      raw_log[6'(cyc)]   <= btn_raw;
      m_state            <= m_state ^ m_accept;
      m_press            <= m_accept & m_now;
      m_release          <= m_accept & ~m_now;
      for (int i = 0; i < N; i++) begin
        if (m_accept[i]) m_rise[i] <= cyc;
`ifdef BTN_HOLD_EN
        m_hold[i] <= m_state[i] && (cyc - m_rise[i] == HOLD_MAX);
`else
        m_hold[i] <= 1'b0;
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_state",   32'(btn_state),   32'(m_state));
      check("model_press",   32'(btn_press),   32'(m_press));
      check("model_release", 32'(btn_release), 32'(m_release));
      check("model_hold",    32'(btn_hold),    32'(m_hold));
    end
  end

  task automatic drive(input logic [N-1:0] v);
    @(negedge clk);
    btn_raw = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // sel: 0 press, 1 release, 2 hold. lat = negedges until first nonzero pulse, 0 on timeout.
  task automatic wait_event(input int sel, input int bound, output int lat, output logic [N-1:0] val);
    logic [N-1:0] ev;
    lat = 0;
    val = '0;
    for (int n = 1; n <= bound; n++) begin
      @(negedge clk);
      ev = (sel == 0) ? btn_press : (sel == 1) ? btn_release : btn_hold;
      if (ev != '0) begin
        lat = n;
        val = ev;
        break;
      end
    end
  endtask

  typedef struct {
    logic [N-1:0] raw;
    int           cycles;
    logic [N-1:0] st;
    logic [N-1:0] pr;
    logic [N-1:0] rl;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int           lat;
    logic [N-1:0] val, pr_seen, rl_seen;
    int           extra;

    vecs[0] = '{raw: 2'b00, cycles: 20, st: 2'b00, pr: 2'b00, rl: 2'b00};
    vecs[1] = '{raw: 2'b01, cycles: 40, st: 2'b01, pr: 2'b01, rl: 2'b00};
    vecs[2] = '{raw: 2'b11, cycles: 40, st: 2'b11, pr: 2'b10, rl: 2'b00};
    vecs[3] = '{raw: 2'b10, cycles: 40, st: 2'b10, pr: 2'b00, rl: 2'b01};
    vecs[4] = '{raw: 2'b00, cycles: 10, st: 2'b10, pr: 2'b00, rl: 2'b00};
    vecs[5] = '{raw: 2'b10, cycles: 30, st: 2'b10, pr: 2'b00, rl: 2'b00};
    vecs[6] = '{raw: 2'b00, cycles: 40, st: 2'b00, pr: 2'b00, rl: 2'b10};

    rstn    = 1'b0;
    btn_raw = '0;
    idle(2);
    check("reset_state",   32'(btn_state),   32'h0);
    check("reset_press",   32'(btn_press),   32'h0);
    check("reset_release", 32'(btn_release), 32'h0);
    check("reset_hold",    32'(btn_hold),    32'h0);
    @(negedge clk);
    rstn   = 1'b1;
    chk_en = 1'b1;

    for (int v = 0; v < 7; v++) begin
      drive(vecs[v].raw);
      pr_seen = '0;
      rl_seen = '0;
      for (int c = 0; c < vecs[v].cycles; c++) begin
        @(negedge clk);
        pr_seen |= btn_press;
        rl_seen |= btn_release;
      end
      check($sformatf("vec%0d_state", v),   32'(btn_state), 32'(vecs[v].st));
      check($sformatf("vec%0d_press", v),   32'(pr_seen),   32'(vecs[v].pr));
      check($sformatf("vec%0d_release", v), 32'(rl_seen),   32'(vecs[v].rl));
    end

    // Short pulses on channel 0 never qualify.
    pr_seen = '0;
    for (int r = 0; r < 3; r++) begin
      drive(2'b01);
      for (int c = 0; c < 10; c++) begin @(negedge clk); pr_seen |= btn_press | btn_release; end
      drive(2'b00);
      for (int c = 0; c < 5; c++) begin @(negedge clk); pr_seen |= btn_press | btn_release; end
    end
    idle(20);
    check("glitch_state",  32'(btn_state), 32'h0);
    check("glitch_pulses", 32'(pr_seen),   32'h0);

    // Bounce then steady high: one press, timed from the final edge.
    for (int b = 0; b < 4; b++) begin
      drive((b % 2 == 0) ? 2'b01 : 2'b00);
      idle(2);
    end
    drive(2'b01);
    wait_event(0, 40, lat, val);
    check("bounce_latency", 32'(lat), 32'(LAT));
    check("bounce_press",   32'(val), 32'h1);

    // Simultaneous press on both channels, then channel 1 releases alone.
    drive(2'b00);
    idle(40);
    drive(2'b11);
    wait_event(0, 40, lat, val);
    check("dual_latency", 32'(lat), 32'(LAT));
    check("dual_press",   32'(val), 32'h3);
    idle(10);
    drive(2'b01);
    wait_event(1, 40, lat, val);
    check("ch1_rel_latency", 32'(lat), 32'(LAT));
    check("ch1_release",     32'(val), 32'h2);

    // Async reset mid-count, then full requalification.
    drive(2'b10);
    idle(40);
    check("pre_reset_state", 32'(btn_state), 32'h2);
    drive(2'b11);
    idle(12);
    #1 rstn = 1'b0;
    #1;
    check("async_reset_state",   32'(btn_state),   32'h0);
    check("async_reset_press",   32'(btn_press),   32'h0);
    check("async_reset_release", 32'(btn_release), 32'h0);
    idle(3);
    rstn = 1'b1;
    wait_event(0, 40, lat, val);
    check("requal_latency", 32'(lat), 32'(LAT));
    check("requal_press",   32'(val), 32'h3);

    // Long press on channel 0.
    drive(2'b00);
    idle(40);
    drive(2'b01);
    wait_event(0, 40, lat, val);
    check("hold_setup_press", 32'(val), 32'h1);
    wait_event(2, 120, lat, val);
`ifdef BTN_HOLD_EN
    check("hold_latency", 32'(lat), 32'(HOLD_MAX));
    check("hold_pulse",   32'(val), 32'h1);
`else
    check("hold_latency", 32'(lat), 32'h0);
    check("hold_pulse",   32'(val), 32'h0);
`endif
    extra = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (btn_hold != '0) extra++;
    end
    check("hold_no_repeat", 32'(extra), 32'h0);

    // Random segments: mix of glitches and accepted levels.
    repeat (80) begin
      drive(N'($urandom));
      idle($urandom_range(1, 30));
    end
    idle(40);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
